// File: rtl/uart_tx_line_arbiter.sv
// uart_tx_line_arbiter
// Shares one UART TX byte sink between NUM_REQ requesters. Grants rotate
// round-robin and stay locked to one requester until it sends 0x0A, reaches
// MAX_LINE bytes, or leaves its valid low for IDLE_TIMEOUT cycles, so console
// lines never interleave.
// Optional build macro UART_ARB_LINE_TAG_EN: every grant first emits the
// owner's index as an ASCII hex digit followed by ':'.
module uart_tx_line_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_LINE     = 255,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [8*NUM_REQ-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      tx_valid_o,
    output logic [7:0]                tx_data_o,
    input  logic                      tx_ready_i,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner_o,
    output logic                      busy_o,
    output logic                      line_done_o,
    output logic                      timeout_o
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [7:0]    LF        = 8'h0A;
    localparam logic [7:0]    LINE_LAST = 8'(MAX_LINE - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

`ifdef UART_ARB_LINE_TAG_EN
    typedef enum logic [1:0] {IDLE, TAG, SEP, STREAM} state_t;
`else
    typedef enum logic [0:0] {IDLE, STREAM} state_t;
`endif

    state_t          state;
    state_t          state_d;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last;
    logic [7:0]      byte_cnt;
    logic [IW-1:0]   idle_cnt;

    logic            pick_en;
    logic [OW-1:0]   pick_idx;
    logic [OW:0]     cand;
    logic            grant;
    logic            rel;
    logic            rel_to;
    logic            xfer;

    logic [NUM_REQ-1:0] owner_oh;
    logic               own_valid;
    logic [7:0]         own_byte;
    logic [7:0]         byte_acc [0:NUM_REQ];

    // One-hot of the current owner drives both the valid and the byte mux.
    assign owner_oh    = NUM_REQ'(1) << owner;
    assign own_valid   = |(req_valid_i & owner_oh);
    assign byte_acc[0] = 8'h00;

    genvar k;
    generate
        for (k = 0; k < NUM_REQ; k++) begin : gen_mux
            assign byte_acc[k+1] = byte_acc[k]
                                 | (owner_oh[k] ? req_data_i[8*k +: 8] : 8'h00);
        end
    endgenerate

    assign own_byte = byte_acc[NUM_REQ];
    assign xfer     = (state == STREAM) && own_valid && tx_ready_i;
    assign owner_o  = owner;
    assign busy_o   = (state != IDLE);

`ifdef UART_ARB_LINE_TAG_EN
    logic [7:0] tag_num;
    logic [7:0] tag_byte;
    assign tag_num  = 8'(owner);
    assign tag_byte = (tag_num < 8'd10) ? (8'h30 + tag_num) : (8'h37 + tag_num);
`endif

    // Round-robin pick: first valid requester after the last grant, wrapping.
    always_comb begin
        pick_en  = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last} + (OW+1)'(i);
            if (cand >= (OW+1)'(NUM_REQ)) begin
                cand = cand - (OW+1)'(NUM_REQ);
            end
            if (!pick_en && (|(req_valid_i & (NUM_REQ'(1) << cand)))) begin
                pick_en  = 1'b1;
                pick_idx = cand[OW-1:0];
            end
        end
    end

    // Next-state and handshake outputs; release decided from the owner's byte.
    always_comb begin
        state_d     = state;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        req_ready_o = '0;
        grant       = 1'b0;
        rel         = 1'b0;
        rel_to      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_en) begin
                    grant = 1'b1;
`ifdef UART_ARB_LINE_TAG_EN
                    state_d = TAG;
`else
                    state_d = STREAM;
`endif
                end
            end
`ifdef UART_ARB_LINE_TAG_EN
            TAG: begin
                tx_valid_o = 1'b1;
                tx_data_o  = tag_byte;
                if (tx_ready_i) begin
                    state_d = SEP;
                end
            end
            SEP: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h3A;
                if (tx_ready_i) begin
                    state_d = STREAM;
                end
            end
`endif
            STREAM: begin
                tx_valid_o  = own_valid;
                tx_data_o   = own_byte;
                req_ready_o = tx_ready_i ? owner_oh : '0;
                if (own_valid && tx_ready_i) begin
                    // A line feed landing on the last allowed byte is one release.
                    if ((own_byte == LF) || (byte_cnt == LINE_LAST)) begin
                        rel = 1'b1;
                    end
                end else if (!own_valid && (idle_cnt == IDLE_LAST)) begin
                    rel    = 1'b1;
                    rel_to = 1'b1;
                end
                if (rel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Owner/rotation pointer, line and idle counters, release pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= '0;
            last        <= OW'(NUM_REQ - 1);
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            line_done_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            line_done_o <= rel;
            timeout_o   <= rel_to;
            if (grant) begin
                owner <= pick_idx;
                last  <= pick_idx;
            end
            if (rel) begin
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else if (state == STREAM) begin
                if (xfer) begin
                    byte_cnt <= byte_cnt + 8'd1;
                end
                // Any cycle with the owner presenting a byte (sent or stalled)
                // restarts the idle window; a slow UART never times out.
                if (own_valid) begin
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Directed bench for uart_tx_line_arbiter (NUM_REQ=4, MAX_LINE=4,
// IDLE_TIMEOUT=1024, tag feature off). Per-cycle vector table plus hand
// sequences for long stalls, idle timeout and mid-line reset.
module tb_uart_tx_line_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic [1:0]  owner;
    logic        busy;
    logic        line_done;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    uart_tx_line_arbiter #(
        .NUM_REQ(4),
        .MAX_LINE(4),
        .IDLE_TIMEOUT(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid),
        .req_data_i(req_data),
        .req_ready_o(req_ready),
        .tx_valid_o(tx_valid),
        .tx_data_o(tx_data),
        .tx_ready_i(tx_ready),
        .owner_o(owner),
        .busy_o(busy),
        .line_done_o(line_done),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pr;   // pulse reset before this row
        logic [3:0]  v;
        logic [31:0] d;
        logic        r;
        logic        ev;
        logic [7:0]  ed;
        logic [3:0]  er;
        logic [1:0]  eo;
        logic        eb;
        logic        eld;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic pr, input logic [3:0] v, input logic [31:0] d,
                       input logic r, input logic ev, input logic [7:0] ed,
                       input logic [3:0] er, input logic [1:0] eo,
                       input logic eb, input logic eld);
        vec_t t;
        t.pr = pr; t.v = v; t.d = d; t.r = r; t.ev = ev; t.ed = ed;
        t.er = er; t.eo = eo; t.eb = eb; t.eld = eld;
        tbl.push_back(t);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " tx_valid"}, 32'(tx_valid), 0);
        chk({tag, " tx_data"}, 32'(tx_data), 0);
        chk({tag, " req_ready"}, 32'(req_ready), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " line_done"}, 32'(line_done), 0);
        chk({tag, " timeout"}, 32'(timeout), 0);
        chk({tag, " owner"}, 32'(owner), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   stall_bad;
        int   early;
        logic saw_pulse;
        string n;

        // Reset + "Hi\n" from requester 0
        add(1, 4'b0001, 32'h00000048, 1, 0, 8'h00, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0001, 32'h00000048, 1, 1, 8'h48, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0001, 32'h00000069, 1, 1, 8'h69, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0001, 32'h0000000A, 1, 1, 8'h0A, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0000, 2'd0, 0, 0);
        // Contention: all four send "A\n", order 0,1,2,3 with an IDLE cycle between
        add(1, 4'b1111, 32'h41414141, 1, 0, 8'h00, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 32'h41414141, 1, 1, 8'h41, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 32'h4141410A, 1, 1, 8'h0A, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1110, 32'h41414100, 1, 0, 8'h00, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1110, 32'h41414100, 1, 1, 8'h41, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1110, 32'h41410A00, 1, 1, 8'h0A, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1100, 32'h41410000, 1, 0, 8'h00, 4'b0000, 2'd1, 0, 1);
        add(0, 4'b1100, 32'h41410000, 1, 1, 8'h41, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1100, 32'h410A0000, 1, 1, 8'h0A, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1000, 32'h41000000, 1, 0, 8'h00, 4'b0000, 2'd2, 0, 1);
        add(0, 4'b1000, 32'h41000000, 1, 1, 8'h41, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b1000, 32'h0A000000, 1, 1, 8'h0A, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0000, 2'd3, 0, 1);
        // Fairness: after owner 2, req0 beats req2; with req3 pending, 3 goes first
        add(0, 4'b0100, 32'h000A0000, 1, 0, 8'h00, 4'b0000, 2'd3, 0, 0);
        add(0, 4'b0100, 32'h000A0000, 1, 1, 8'h0A, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0101, 32'h00410041, 1, 0, 8'h00, 4'b0000, 2'd2, 0, 1);
        add(0, 4'b0101, 32'h00410041, 1, 1, 8'h41, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0101, 32'h00410041, 0, 1, 8'h41, 4'b0000, 2'd0, 1, 0);
        add(0, 4'b0101, 32'h0041000A, 1, 1, 8'h0A, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0100, 32'h00410000, 1, 0, 8'h00, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b0100, 32'h00410000, 1, 1, 8'h41, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0100, 32'h000A0000, 1, 1, 8'h0A, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1101, 32'h41410041, 1, 0, 8'h00, 4'b0000, 2'd2, 0, 1);
        add(0, 4'b1101, 32'h41410041, 1, 1, 8'h41, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b1101, 32'h0A410041, 1, 1, 8'h0A, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b0101, 32'h00410041, 1, 0, 8'h00, 4'b0000, 2'd3, 0, 1);
        add(0, 4'b0101, 32'h00410041, 1, 1, 8'h41, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0101, 32'h0041000A, 1, 1, 8'h0A, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0100, 32'h00410000, 1, 0, 8'h00, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b0100, 32'h00410000, 1, 1, 8'h41, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0100, 32'h000A0000, 1, 1, 8'h0A, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0000, 2'd2, 0, 1);
        // MAX_LINE=4: req1 sends 01..06, split after byte 4, then drops valid
        add(0, 4'b0010, 32'h00000100, 1, 0, 8'h00, 4'b0000, 2'd2, 0, 0);
        add(0, 4'b0010, 32'h00000100, 1, 1, 8'h01, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b0010, 32'h00000200, 1, 1, 8'h02, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b0010, 32'h00000300, 1, 1, 8'h03, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b0010, 32'h00000400, 1, 1, 8'h04, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b0010, 32'h00000500, 1, 0, 8'h00, 4'b0000, 2'd1, 0, 1);
        add(0, 4'b0010, 32'h00000500, 1, 1, 8'h05, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b0010, 32'h00000600, 1, 1, 8'h06, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b0000, 32'h00000000, 1, 0, 8'h00, 4'b0010, 2'd1, 1, 0);

        // Initial reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk_all_zero("por");

        foreach (tbl[i]) begin
            if (tbl[i].pr) pulse_reset();
            else @(negedge clk);
            req_valid = tbl[i].v;
            req_data  = tbl[i].d;
            tx_ready  = tbl[i].r;
            #2;
            n = $sformatf("row%0d", i);
            chk({n, " tx_valid"}, 32'(tx_valid), 32'(tbl[i].ev));
            chk({n, " tx_data"}, 32'(tx_data), 32'(tbl[i].ed));
            chk({n, " req_ready"}, 32'(req_ready), 32'(tbl[i].er));
            chk({n, " owner"}, 32'(owner), 32'(tbl[i].eo));
            chk({n, " busy"}, 32'(busy), 32'(tbl[i].eb));
            chk({n, " line_done"}, 32'(line_done), 32'(tbl[i].eld));
            chk({n, " timeout"}, 32'(timeout), 0);
        end

        // Mid-line reset while req1 owns the line; req0 gets the next grant
        @(negedge clk);
        req_valid = 4'b0011;
        req_data  = 32'h00000102;
        tx_ready  = 1'b1;
        #2;
        chk("midline busy", 32'(busy), 1);
        chk("midline tx_data", 32'(tx_data), 32'h01);
        rst = 1'b1;
        #1;
        chk_all_zero("midline reset");
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("post-reset idle busy", 32'(busy), 0);
        @(negedge clk);
        #2;
        chk("post-reset owner", 32'(owner), 0);
        chk("post-reset busy", 32'(busy), 1);
        chk("post-reset tx_data", 32'(tx_data), 32'h02);
        chk("post-reset req_ready", 32'(req_ready), 32'h1);

        // Long UART stall must not time out; then owner idle forces release
        pulse_reset();
        req_valid = 4'b0001;
        req_data  = 32'h00000055;
        tx_ready  = 1'b0;
        #2;
        chk("stall idle tx_valid", 32'(tx_valid), 0);
        stall_bad = 0;
        saw_pulse = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #2;
            if (tx_valid !== 1'b1 || tx_data !== 8'h55 || req_ready !== 4'b0000 || busy !== 1'b1)
                stall_bad++;
            if (line_done || timeout) saw_pulse = 1'b1;
        end
        chk("stall outputs held", 32'(stall_bad), 0);
        chk("stall no release", 32'(saw_pulse), 0);
        @(negedge clk);
        tx_ready = 1'b1;
        #2;
        chk("stall end tx_valid", 32'(tx_valid), 1);
        chk("stall end req_ready", 32'(req_ready), 32'h1);
        early = 0;
        for (int j = 1; j <= 1024; j++) begin
            @(negedge clk);
            req_valid = 4'b0000;
            #2;
            if (!busy || line_done || timeout) early++;
        end
        chk("idle no early release", 32'(early), 0);
        @(negedge clk);
        #2;
        chk("timeout line_done", 32'(line_done), 1);
        chk("timeout pulse", 32'(timeout), 1);
        chk("timeout busy", 32'(busy), 0);
        chk("timeout owner", 32'(owner), 0);
        @(negedge clk);
        #2;
        chk("timeout line_done end", 32'(line_done), 0);
        chk("timeout pulse end", 32'(timeout), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
